// File: rtl/io_access_arbiter.sv
// Round-robin arbiter for the shared processor-side I/O access port.
// One command in flight: IDLE -> ISSUE -> (WAIT ->) RESP -> IDLE.
module io_access_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_W     = 30,
    parameter int RD_LATENCY = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [N_REQ-1:0]        Req_Valid,
    input  logic [N_REQ-1:0]        Req_WrEn,
    input  logic [N_REQ*ADDR_W-1:0] Req_Address,
    input  logic [N_REQ*32-1:0]     Req_WrData,
    output logic [N_REQ-1:0]        Req_Ready,
    output logic [N_REQ-1:0]        Rsp_Valid,
    output logic [31:0]             Rsp_RdData,
    output logic [ADDR_W-1:0]       Sys_Address,
    output logic [31:0]             Sys_WrData,
    output logic                    Sys_WrEn,
    output logic                    Sys_RdEn,
    input  logic [31:0]             Sys_RdData
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                found;
    logic [PW-1:0]       gnt;
    logic [PW-1:0]       cand;
    logic [N_REQ-1:0]    grant_oh;

    // Search upward from the slot after the last grant, wrapping at N_REQ.
    always_comb begin
        found = 1'b0;
        gnt   = ptr_q;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % N_REQ);
            if (!found && Req_Valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ISSUE;
                    ptr_d   = gnt;
                    wr_d    = Req_WrEn[gnt];
                    addr_d  = Req_Address[int'(gnt)*ADDR_W +: ADDR_W];
                    wdata_d = Req_WrData[int'(gnt)*32 +: 32];
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = 3'(RD_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = Sys_RdData;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= PW'(N_REQ - 1);
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // The pointer always holds the requester currently being served.
    assign grant_oh    = N_REQ'(1) << ptr_q;
    assign Req_Ready   = (state_q == ISSUE) ? grant_oh : '0;
    assign Rsp_Valid   = (state_q == RESP) ? grant_oh : '0;
    assign Sys_WrEn    = (state_q == ISSUE) && wr_q;
    assign Sys_RdEn    = (state_q == ISSUE) && !wr_q;
    assign Sys_Address = addr_q;
    assign Sys_WrData  = wdata_q;
    assign Rsp_RdData  = rdata_q;

endmodule

// File: tb/tb_io_access_arbiter.sv
// Scoreboard bench for io_access_arbiter: random requesters, memory-backed
// I/O device and a transaction-level round-robin reference model.
module tb_io_access_arbiter;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int L  = 1;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [N-1:0]  Req_Valid;
    logic [N-1:0]  Req_WrEn;
    logic [N*AW-1:0] Req_Address;
    logic [N*32-1:0] Req_WrData;
    logic [N-1:0]  Req_Ready;
    logic [N-1:0]  Rsp_Valid;
    logic [31:0]   Rsp_RdData;
    logic [AW-1:0] Sys_Address;
    logic [31:0]   Sys_WrData;
    logic          Sys_WrEn;
    logic          Sys_RdEn;
    logic [31:0]   Sys_RdData;

    logic [N-1:0]  v3, w3, rdy3, rv3;
    logic [N*AW-1:0] a3;
    logic [N*32-1:0] d3;
    logic [31:0]   rd3, srd3, swd3;
    logic [AW-1:0] sa3;
    logic          swe3, sre3;

    io_access_arbiter #(.N_REQ(N), .ADDR_W(AW), .RD_LATENCY(L)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req_Valid(Req_Valid), .Req_WrEn(Req_WrEn),
        .Req_Address(Req_Address), .Req_WrData(Req_WrData),
        .Req_Ready(Req_Ready), .Rsp_Valid(Rsp_Valid),
        .Rsp_RdData(Rsp_RdData), .Sys_Address(Sys_Address),
        .Sys_WrData(Sys_WrData), .Sys_WrEn(Sys_WrEn),
        .Sys_RdEn(Sys_RdEn), .Sys_RdData(Sys_RdData)
    );

    io_access_arbiter #(.N_REQ(N), .ADDR_W(AW), .RD_LATENCY(3)) dut3 (
        .Clock(Clock), .Reset(Reset),
        .Req_Valid(v3), .Req_WrEn(w3),
        .Req_Address(a3), .Req_WrData(d3),
        .Req_Ready(rdy3), .Rsp_Valid(rv3),
        .Rsp_RdData(rd3), .Sys_Address(sa3),
        .Sys_WrData(swd3), .Sys_WrEn(swe3),
        .Sys_RdEn(sre3), .Sys_RdData(srd3)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int          c;
        int          g;
        bit          wr;
        logic [29:0] a;
        logic [31:0] d;
    } iss_t;

    typedef struct {
        int          c;
        int          g;
        logic [31:0] d;
    } rsp_t;

    iss_t iq[$];
    rsp_t rq[$];

    bit   [N-1:0]  pend;
    bit            cw[N];
    logic [29:0]   ca[N];
    logic [31:0]   cd[N];

    int            m_last = N - 1;
    int            m_free = 0;
    int            m_iss  = -100;
    logic [31:0]   m_rd   = '0;
    logic [31:0]   ref_mem[16];
    logic [31:0]   dev_mem[16];
    int            rd_due = -1;
    logic [3:0]    rd_idx = '0;
    int            gen_pct = 0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            Req_Valid[i] = pend[i];
            Req_WrEn[i]  = cw[i];
            Req_Address[i*AW +: AW] = ca[i];
            Req_WrData[i*32 +: 32]  = cd[i];
        end
    endtask

    task automatic post(input int i, input bit wr,
                        input logic [29:0] a, input logic [31:0] d);
        pend[i] = 1'b1;
        cw[i]   = wr;
        ca[i]   = a;
        cd[i]   = d;
        drive();
    endtask

    // One clock of requesters, I/O device and reference model.
    task automatic step();
        logic [N-1:0] rdy;
        logic         rst_s;
        int           g;
        rsp_t         r;
        @(negedge Clock);
        rdy   = Req_Ready;
        rst_s = Reset;
        if (Sys_WrEn) dev_mem[Sys_Address[3:0]] = Sys_WrData;
        if (Sys_RdEn) begin
            rd_due = cyc + L;
            rd_idx = Sys_Address[3:0];
        end
        @(posedge Clock);
        #1;
        if (rst_s) begin
            m_last = N - 1;
            m_free = cyc;
        end else if (cyc - 1 >= m_free && pend != 0) begin
            g = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && pend[(m_last + k) % N]) g = (m_last + k) % N;
            iq.push_back('{cyc, g, cw[g], ca[g], cd[g]});
            if (cw[g]) begin
                ref_mem[ca[g][3:0]] = cd[g];
                r = '{cyc + 1, g, m_rd};
            end else begin
                m_rd = ref_mem[ca[g][3:0]];
                r = '{cyc + 1 + L, g, m_rd};
            end
            rq.push_back(r);
            m_free = r.c + 1;
            m_last = g;
            m_iss  = cyc;
        end
        for (int i = 0; i < N; i++) begin
            if (pend[i] && rdy[i]) pend[i] = 1'b0;
            if (!pend[i] && gen_pct > 0 &&
                $urandom_range(0, 99) < gen_pct)
                post(i, 1'($urandom_range(0, 1)), 30'($urandom), $urandom);
        end
        Sys_RdData = (cyc == rd_due) ? dev_mem[rd_idx] : $urandom;
        drive();
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            step();
            done = (pend == 0) && (iq.size() == 0) && (rq.size() == 0);
        end
        chk("drain_timeout", 64'(done), 64'd1);
    endtask

    // Monitor: pops expected issue/response entries as the DUT presents them.
    initial begin
        iss_t e;
        rsp_t r;
        forever begin
            @(negedge Clock);
            if (iq.size() > 0 && iq[0].c == cyc) begin
                e = iq.pop_front();
                chk("ready_grant", 64'(Req_Ready), 64'(4'b1 << e.g));
                chk("sys_wren", 64'(Sys_WrEn), 64'(e.wr));
                chk("sys_rden", 64'(Sys_RdEn), 64'(!e.wr));
                chk("sys_addr", 64'(Sys_Address), 64'(e.a));
                if (e.wr) chk("sys_wdata", 64'(Sys_WrData), 64'(e.d));
            end else begin
                chk("idle_issue", 64'({Req_Ready, Sys_WrEn, Sys_RdEn}), 64'd0);
            end
            if (rq.size() > 0 && rq[0].c == cyc) begin
                r = rq.pop_front();
                chk("rsp_valid", 64'(Rsp_Valid), 64'(4'b1 << r.g));
                chk("rsp_rddata", 64'(Rsp_RdData), 64'(r.d));
            end else begin
                chk("idle_rsp", 64'(Rsp_Valid), 64'd0);
            end
        end
    end

    initial begin
        int c0, rc, sc;
        logic [31:0] sd;
        logic [N-1:0] sv;
        bit hit;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0;
            dev_mem[i] = '0;
        end
        ref_mem[0] = 32'hCAFE0001;
        dev_mem[0] = 32'hCAFE0001;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            cw[i]   = 1'b0;
            ca[i]   = '0;
            cd[i]   = '0;
        end
        drive();
        Sys_RdData = '0;
        v3 = '0; w3 = '0; a3 = '0; d3 = '0; srd3 = '0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_ctrl", 64'({Req_Ready, Rsp_Valid, Sys_WrEn, Sys_RdEn}), 64'd0);
        chk("rst_addr", 64'(Sys_Address), 64'd0);
        chk("rst_wdata", 64'(Sys_WrData), 64'd0);
        chk("rst_rdata", 64'(Rsp_RdData), 64'd0);
        Reset = 1'b0;

        post(0, 1'b0, 30'h10, 32'h0);
        drain();
        chk("t1_rdata_hold", 64'(Rsp_RdData), 64'hCAFE0001);

        post(2, 1'b1, 30'h23, 32'h55AA);
        drain();

        post(3, 1'b1, 30'h3, 32'h33);
        post(0, 1'b0, 30'h3, 32'h0);
        post(1, 1'b0, 30'h23, 32'h0);
        drain();

        gen_pct = 100;
        repeat (60) step();
        gen_pct = 0;
        drain();

        gen_pct = 30;
        repeat (400) step();
        gen_pct = 0;
        drain();

        m_iss = -100;
        post(0, 1'b0, 30'h5, 32'h0);
        for (int t = 0; t < 10 && cyc != m_iss + 1; t++) step();
        chk("t5_in_wait", 64'(cyc), 64'(m_iss + 1));
        Reset = 1'b1;
        #1;
        chk("t5_async_ctrl",
            64'({Req_Ready, Rsp_Valid, Sys_WrEn, Sys_RdEn}), 64'd0);
        chk("t5_async_data", 64'({Sys_Address, Rsp_RdData}), 64'd0);
        iq.delete();
        rq.delete();
        m_rd   = '0;
        rd_due = -1;
        post(1, 1'b1, 30'h7, 32'h77);
        post(0, 1'b0, 30'h7, 32'h0);
        repeat (2) step();
        Reset = 1'b0;
        drain();

        // Three-cycle read latency instance.
        c0 = cyc;
        v3 = 4'b0001;
        a3[AW-1:0] = 30'h10;
        rc = -1; sc = -1; sd = '0; sv = '0; hit = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge Clock);
            if (rdy3[0] && rc < 0) rc = cyc;
            if (rv3 != 0 && !hit) begin
                hit = 1'b1;
                sc = cyc;
                sd = rd3;
                sv = rv3;
            end
            @(posedge Clock);
            #1;
            srd3 = (cyc == c0 + 4) ? 32'hA5A50003 : $urandom;
            if (rc >= 0) v3 = '0;
        end
        chk("t6_ready_cycle", 64'(rc - c0), 64'd1);
        chk("t6_rsp_cycle", 64'(sc - c0), 64'd5);
        chk("t6_rsp_valid", 64'(sv), 64'd1);
        chk("t6_rsp_data", 64'(sd), 64'hA5A50003);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
